// File: rtl/alu_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer_pkg
//  Purpose  : Shared types and default constants for the ALU command
//             sequencer: ALU opcode set, sequencer states, frame constants.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_cmd_sequencer_pkg;

  // ALU function select. Codes 14 and 15 are unused and rejected by the
  // sequencer before they ever reach the ALU Enable.
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_DIV   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_NAND  = 4'd6,
    OP_NOR   = 4'd7,
    OP_XOR   = 4'd8,
    OP_XNOR  = 4'd9,
    OP_CMPEQ = 4'd10,
    OP_CMPGT = 4'd11,
    OP_SHR   = 4'd12,
    OP_SHL   = 4'd13
  } opcode_t;

  // Frame collection, ALU handshake and response transmission states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_A    = 3'd1,
    GET_B    = 3'd2,
    EXEC     = 3'd3,
    WAIT     = 3'd4,
    SEND_HI  = 3'd5,
    SEND_LO  = 3'd6,
    SEND_ERR = 3'd7
  } seq_state_t;

  localparam logic [3:0] CMD_TAG_DEFAULT        = 4'hA;
  localparam logic [7:0] ERR_CODE_DEFAULT       = 8'hEE;
  localparam int         NUM_OPS_DEFAULT        = 14;
  localparam int         TIMEOUT_CYCLES_DEFAULT = 16;

endpackage : alu_cmd_sequencer_pkg
`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer_if
//  Purpose  : Bundles the RX byte stream, ALU drive/return and TX byte
//             stream of the sequencer. master = sequencer, slave = its
//             environment (byte source, ALU, byte sink).
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  import alu_cmd_sequencer_pkg::*;

  // RX byte stream
  logic [DATA_WIDTH-1:0]   RX_DATA;
  logic                    RX_VALID;
  logic                    RX_READY;
  // ALU drive and result
  logic                    ALU_EN;
  logic [DATA_WIDTH-1:0]   ALU_A;
  logic [DATA_WIDTH-1:0]   ALU_B;
  opcode_t                 ALU_FUN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VALID;
  // TX byte stream
  logic [DATA_WIDTH-1:0]   TX_DATA;
  logic                    TX_VALID;
  logic                    TX_READY;

  modport master (
    input  RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
    output RX_READY, ALU_EN, ALU_A, ALU_B, ALU_FUN, TX_DATA, TX_VALID
  );

  modport slave (
    output RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
    input  RX_READY, ALU_EN, ALU_A, ALU_B, ALU_FUN, TX_DATA, TX_VALID
  );

endinterface : alu_cmd_sequencer_if
`default_nettype wire

// File: rtl/alu_cmd_sequencer_seq_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer_seq_timeout_cnt
//  Purpose  : Clear/enable up-counter with a terminal-count flag that is
//             high while the count equals TERMINAL-1. Used to bound the
//             wait for the ALU result.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer_seq_timeout_cnt #(
  parameter int TERMINAL = 16
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic clr_i,
  input  wire logic en_i,
  output logic      tc_o
);

  localparam int CW = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(TERMINAL - 1));

endmodule : alu_cmd_sequencer_seq_timeout_cnt
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Purpose  : Collects a command/A/B frame from the RX byte stream, fires a
//             single-cycle ALU Enable, waits (bounded) for the result and
//             returns it high byte first on the TX stream, or an error code.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [3:0]            CMD_TAG        = CMD_TAG_DEFAULT,
  parameter int                    TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] ERR_CODE       = DATA_WIDTH'(ERR_CODE_DEFAULT),
  parameter int                    NUM_OPS        = NUM_OPS_DEFAULT
) (
  input  wire logic           CLK,
  input  wire logic           RST,
  alu_cmd_sequencer_if.master bus,
  output logic                BUSY,
  output logic                ERR
);

  seq_state_t                state_q, state_d;
  opcode_t                   fun_q, fun_d;
  logic [DATA_WIDTH-1:0]     a_q, a_d;
  logic [DATA_WIDTH-1:0]     b_q, b_d;
  logic [2*DATA_WIDTH-1:0]   res_q, res_d;
  logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;

  logic w_rx_ready;
  logic w_rx_take;
  logic w_err;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_timeout;

  // Bytes are only consumed while a frame is being collected.
  assign w_rx_ready = (state_q == IDLE) || (state_q == GET_A) || (state_q == GET_B);
  assign w_rx_take  = bus.RX_VALID && w_rx_ready;

  // Next-state, datapath loads and error/counter strobes.
  always_comb begin
    state_d   = state_q;
    fun_d     = fun_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    tx_data_d = tx_data_q;
    w_err     = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_rx_take) begin
          if (bus.RX_DATA[7:4] == CMD_TAG) begin
            fun_d   = opcode_t'(bus.RX_DATA[3:0]);
            state_d = GET_A;
          end else begin
            // Untagged byte is dropped without any reply.
            w_err = 1'b1;
          end
        end
      end
      GET_A: begin
        if (w_rx_take) begin
          a_d     = bus.RX_DATA;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (w_rx_take) begin
          b_d = bus.RX_DATA;
          if (int'(fun_q) < NUM_OPS) begin
            state_d = EXEC;
          end else begin
            w_err     = 1'b1;
            tx_data_d = ERR_CODE;
            state_d   = SEND_ERR;
          end
        end
      end
      EXEC: begin
        w_cnt_clr = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.ALU_OUT_VALID) begin
          res_d     = bus.ALU_OUT;
          tx_data_d = bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = SEND_HI;
        end else if (w_timeout) begin
          w_err     = 1'b1;
          tx_data_d = ERR_CODE;
          state_d   = SEND_ERR;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      SEND_HI: begin
        if (bus.TX_READY) begin
          tx_data_d = res_q[DATA_WIDTH-1:0];
          state_d   = SEND_LO;
        end
      end
      SEND_LO, SEND_ERR: begin
        if (bus.TX_READY) begin
          tx_data_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      fun_q     <= opcode_t'(4'd0);
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      fun_q     <= fun_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      tx_data_q <= tx_data_d;
    end
  end

  alu_cmd_sequencer_seq_timeout_cnt #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (w_cnt_clr),
    .en_i   (w_cnt_en),
    .tc_o   (w_timeout)
  );

  // All stream/ALU outputs come straight from registers or the state register.
  assign bus.RX_READY = w_rx_ready;
  assign bus.ALU_EN   = (state_q == EXEC);
  assign bus.ALU_A    = a_q;
  assign bus.ALU_B    = b_q;
  assign bus.ALU_FUN  = fun_q;
  assign bus.TX_VALID = (state_q == SEND_HI) || (state_q == SEND_LO) || (state_q == SEND_ERR);
  assign bus.TX_DATA  = tx_data_q;
  assign BUSY         = (state_q != IDLE);
  assign ERR          = w_err;

endmodule : alu_cmd_sequencer
`default_nettype wire
